fifo_rd_stream: RTL and testbench

Read-side drain engine for the dual-clock FIFO: runs in the read clock domain, issues read strobes to the FIFO read port, absorbs the one-cycle registered RAM read latency, and presents the data as a valid/ready stream. It sits between the FIFO read port and any downstream consumer that can stall. It sustains one beat per cycle with no bubbles and never loses or duplicates a word under backpressure.

---
 rtl/fifo_rd_stream_pkg.sv | 21 ++
 rtl/fifo_rd_stream_skid_buf.sv | 59 +++++
 rtl/fifo_rd_stream.sv | 105 ++++++++++
 tb/tb_fifo_rd_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and elaboration helpers for the fifo_rd_stream read-side drain engine.
package fifo_rd_stream_pkg;

  // Status encoding, derived from occupancy and the in-flight flag
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FULL   = 2'd2
  } stream_status_e;

  localparam int unsigned STAT_W = 16;

  function automatic bit buf_depth_legal(input int unsigned depth);
    return (depth == 2) || (depth == 4);
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf.sv
// Register-file FIFO that absorbs the RAM read latency and holds words while the consumer stalls.
module fifo_rd_stream_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        head,
  output logic [$clog2(BUF_DEPTH):0]   occ
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W = occ_width(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  do_push_c, do_pop_c;

  // Pointers wrap naturally because the depth is a power of two
  always_comb begin
    do_pop_c  = pop && (occ_q != '0);
    do_push_c = push && ((occ_q != OCC_W'(BUF_DEPTH)) || do_pop_c);
    mem_d     = mem_q;
    if (do_push_c) begin
      mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop_c);
    occ_d    = occ_q + OCC_W'(do_push_c) - OCC_W'(do_pop_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: issues FIFO reads, captures the delayed data and presents a valid/ready stream.
// Optional beat/stall statistics are compiled in when FIFO_RD_STREAM_STAT_EN is defined.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst_n,
  input  logic                         fifo_empty,
  input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
  output logic                         fifo_rd_en,
  input  logic                         halt,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  input  logic                         m_ready,
  output logic [$clog2(BUF_DEPTH):0]   buf_occ
`ifdef FIFO_RD_STREAM_STAT_EN
  ,
  output logic [STAT_W-1:0]            beat_cnt,
  output logic [STAT_W-1:0]            stall_cnt
`endif
);

  localparam int unsigned OCC_W = occ_width(BUF_DEPTH);
  localparam int unsigned SUM_W = OCC_W + 1;

  if (!buf_depth_legal(BUF_DEPTH)) begin : g_bad_depth
    $error("fifo_rd_stream: BUF_DEPTH must be 2 or 4");
  end

  logic             init_q, init_d;
  logic             inflight_q, inflight_d;
  logic             pop_c;
  logic [SUM_W-1:0] committed_c;
  logic [OCC_W-1:0] occ;

  // init masks the post-reset fifo_empty value for one cycle
  always_comb begin
    init_d     = 1'b0;
    inflight_d = fifo_rd_en;
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      init_q     <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      init_q     <= init_d;
      inflight_q <= inflight_d;
    end
  end

  // Issue only if the word will have a slot once this cycle's capture and pop settle
  always_comb begin
    pop_c       = m_valid && m_ready;
    committed_c = SUM_W'(occ) + SUM_W'(inflight_q) - SUM_W'(pop_c);
    fifo_rd_en  = !init_q && !halt && !fifo_empty && (committed_c < SUM_W'(BUF_DEPTH));
  end

  fifo_rd_stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skid_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (pop_c),
    .head      (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != '0);
  assign buf_occ = occ;

`ifdef FIFO_RD_STREAM_STAT_EN
  logic [STAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Beats wrap; stall cycles saturate
  always_comb begin
    beat_cnt_d  = beat_cnt_q + STAT_W'(pop_c);
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: per-cycle vector tables plus sequences for backpressure and reset.
module tb_fifo_rd_stream;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned OCC_W = 2;

  logic             rd_clk       = 1'b0;
  logic             rd_rst_n     = 1'b0;
  logic             fifo_empty   = 1'b1;
  logic [DW-1:0]    fifo_rd_data = '0;
  logic             halt         = 1'b0;
  logic             m_ready      = 1'b0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic [OCC_W-1:0] buf_occ;
`ifdef FIFO_RD_STREAM_STAT_EN
  logic [15:0]      beat_cnt, stall_cnt;
  logic [15:0]      exp_beats  = '0;
  logic [15:0]      exp_stalls = '0;
`endif

  int errors = 0;
  int checks = 0;
  int underflow = 0;
  logic [DW-1:0] wcnt = 4'd1;
  logic [DW-1:0] fifo_q [$];

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .halt         (halt),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .buf_occ      (buf_occ)
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    .beat_cnt     (beat_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  // FIFO read port model: registered read data and registered empty flag
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() == 0) underflow++;
      else fifo_rd_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
`ifdef FIFO_RD_STREAM_STAT_EN
    if (!rd_rst_n) begin
      exp_beats  <= '0;
      exp_stalls <= '0;
    end else begin
      if (m_valid && m_ready) exp_beats <= exp_beats + 16'd1;
      if (m_valid && !m_ready && exp_stalls != 16'hFFFF) exp_stalls <= exp_stalls + 16'd1;
    end
`endif
  end

  typedef struct {
    int         load;
    logic       halt;
    logic       ready;
    logic       rd_en;
    logic       valid;
    logic [3:0] data;
    logic [1:0] occ;
  } row_t;

  function automatic row_t mk(int load, int h, int r, int e, int v, int d, int o);
    row_t t;
    t.load  = load;
    t.halt  = 1'(h);
    t.ready = 1'(r);
    t.rd_en = 1'(e);
    t.valid = 1'(v);
    t.data  = 4'(d);
    t.occ   = 2'(o);
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_word();
    fifo_q.push_back(wcnt);
    wcnt = wcnt + 4'd1;
  endtask

  task automatic apply_row(input row_t r, input string tag);
    @(negedge rd_clk);
    halt    = r.halt;
    m_ready = r.ready;
    for (int k = 0; k < r.load; k++) push_word();
    #1;
    check({tag, " rd_en"},   int'(fifo_rd_en), int'(r.rd_en));
    check({tag, " m_valid"}, int'(m_valid),    int'(r.valid));
    check({tag, " buf_occ"}, int'(buf_occ),    int'(r.occ));
    if (r.valid) check({tag, " m_data"}, int'(m_data), int'(r.data));
  endtask

  row_t t1 [$];
  row_t t2 [$];

  initial begin
    int            got;
    int            max_occ;
    int            n;
    logic [DW-1:0] exp_word;

    // Stream of 1..5 with m_ready high, then 8 words against a stalled consumer
    t1.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    t1.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    t1.push_back(mk(0, 0, 1, 1, 1, 1, 1));
    t1.push_back(mk(0, 0, 1, 1, 1, 2, 1));
    t1.push_back(mk(0, 0, 1, 1, 1, 3, 1));
    t1.push_back(mk(0, 0, 1, 0, 1, 4, 1));
    t1.push_back(mk(0, 0, 1, 0, 1, 5, 1));
    t1.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    t1.push_back(mk(8, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, 0, 1, 6, 1));
    t1.push_back(mk(0, 0, 0, 0, 1, 6, 2));
    t1.push_back(mk(0, 0, 0, 0, 1, 6, 2));
    t1.push_back(mk(0, 0, 0, 0, 1, 6, 2));

    // Halt for 3 cycles mid-stream, then a single word whose issue empties the FIFO
    t2.push_back(mk(6, 0, 1, 0, 0, 0, 0));
    t2.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    t2.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    t2.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    t2.push_back(mk(0, 1, 1, 0, 1, 1, 1));
    t2.push_back(mk(0, 1, 1, 0, 1, 2, 1));
    t2.push_back(mk(0, 1, 1, 0, 0, 0, 0));
    t2.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    t2.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    t2.push_back(mk(0, 0, 1, 1, 1, 3, 1));
    t2.push_back(mk(0, 0, 1, 0, 1, 4, 1));
    t2.push_back(mk(0, 0, 1, 0, 1, 5, 1));
    t2.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    t2.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    t2.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    t2.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    t2.push_back(mk(0, 0, 1, 0, 1, 6, 1));
    t2.push_back(mk(0, 0, 1, 0, 0, 0, 0));

    // Reset with the FIFO preloaded
    rd_rst_n = 1'b0;
    m_ready  = 1'b1;
    repeat (2) @(negedge rd_clk);
    repeat (5) push_word();
    @(negedge rd_clk);
    #1;
    check("reset rd_en",   int'(fifo_rd_en), 0);
    check("reset m_valid", int'(m_valid),    0);
    check("reset m_data",  int'(m_data),     0);
    check("reset buf_occ", int'(buf_occ),    0);
    rd_rst_n = 1'b1;
    #1;
    check("init rd_en", int'(fifo_rd_en), 0);

    for (int i = 0; i < t1.size(); i++) apply_row(t1[i], $sformatf("T1[%0d]", i));

    // Alternating m_ready across 16 words: order, no loss or duplicate, bounded occupancy
    repeat (8) push_word();
    exp_word = 4'd6;
    got      = 0;
    max_occ  = 0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      @(negedge rd_clk);
      m_ready = ((c % 2) == 0);
      #1;
      if (int'(buf_occ) > max_occ) max_occ = int'(buf_occ);
      if (m_valid && m_ready) begin
        check($sformatf("S3 word %0d", got), int'(m_data), int'(exp_word));
        exp_word = exp_word + 4'd1;
        got++;
      end
    end
    check("S3 word count", got, 16);
    check("S3 max occ", max_occ, 2);
    @(negedge rd_clk);
    m_ready = 1'b1;
    #1;
    check("S3 drained m_valid", int'(m_valid), 0);

    wcnt = 4'd0;
    for (int i = 0; i < t2.size(); i++) apply_row(t2[i], $sformatf("T2[%0d]", i));

    // Fill the buffer against a stalled consumer, then pulse reset
    m_ready = 1'b0;
    repeat (3) push_word();
    n = 0;
    do begin
      @(negedge rd_clk);
      #1;
      n++;
    end while (buf_occ != 2'd2 && n < 20);
    check("S6 full occ",     int'(buf_occ), 2);
    check("S6 full m_valid", int'(m_valid), 1);
    check("S6 full m_data",  int'(m_data),  7);
    check("S6 full rd_en",   int'(fifo_rd_en), 0);
`ifdef FIFO_RD_STREAM_STAT_EN
    check("S6 beat_cnt",  int'(beat_cnt),  int'(exp_beats));
    check("S6 stall_cnt", int'(stall_cnt), int'(exp_stalls));
`endif
    @(negedge rd_clk);
    rd_rst_n = 1'b0;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    #1;
    check("S6 post-reset m_valid", int'(m_valid),    0);
    check("S6 post-reset occ",     int'(buf_occ),    0);
    check("S6 post-reset rd_en",   int'(fifo_rd_en), 0);
`ifdef FIFO_RD_STREAM_STAT_EN
    check("S6 post-reset beat_cnt",  int'(beat_cnt),  0);
    check("S6 post-reset stall_cnt", int'(stall_cnt), 0);
`endif
    @(negedge rd_clk);
    #1;
    check("S6 reissue rd_en", int'(fifo_rd_en), 1);
    @(negedge rd_clk);
    check("reads from empty FIFO", underflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
